// File: rtl/sysid_check_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sysid_check_ctrl_if
// Description : Avalon-MM read-only bus between the sysid checker (master)
//               and the system-ID control slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface sysid_check_ctrl_if;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface
`default_nettype wire

// File: rtl/sysid_check_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sysid_check_ctrl
// Description : Reads the system-ID word and build timestamp over Avalon-MM,
//               compares them against build-time constants and reports
//               sticky pass/fail and timeout status. Runs once after reset
//               (optional) and again on every start request taken in IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'h88888888,
  parameter logic [31:0] EXPECTED_TS    = 32'h5844ABF9,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  sysid_check_ctrl_if.master avm,
  output logic               busy,
  output logic               done,
  output logic               id_ok,
  output logic               ts_ok,
  output logic               sysid_ok,
  output logic               timeout_err,
  output logic [31:0]        id_value,
  output logic [31:0]        ts_value
);

  // Last stalled cycle of an access: reaching it with waitrequest still high
  // means the counter hits TIMEOUT_CYCLES and the attempt is abandoned.
  localparam logic [15:0] c_wait_last = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  c_max_retry = 4'(MAX_RETRY);

  // ST_GAP is the single read-low cycle that follows an expired access;
  // the retry/abort decision is taken there.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_ID = 3'd1,
    ST_RD_TS = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_auto_pend;
  logic [15:0] r_wait_cnt;
  logic [3:0]  r_retry_cnt;

  logic        r_read;
  logic        r_addr;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_sysid_ok;
  logic        r_timeout_err;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic        w_in_read;
  logic        w_accept;
  logic        w_expire;
  logic        w_launch;
  logic        w_can_retry;
  logic        w_read_nxt;
  logic        w_addr_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;

  // Next-state and next-output decode; outputs are derived from the next
  // state so that every port is driven straight from a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_in_read   = (r_state == ST_RD_ID) || (r_state == ST_RD_TS);
    w_accept    = w_in_read && !avm.avm_waitrequest;
    w_expire    = w_in_read && avm.avm_waitrequest && (r_wait_cnt == c_wait_last);
    w_launch    = (r_state == ST_IDLE) && (start || r_auto_pend);
    w_can_retry = (r_retry_cnt < c_max_retry);

    case (r_state)
      ST_IDLE: begin
        if (w_launch) w_state_nxt = ST_RD_ID;
      end
      ST_RD_ID: begin
        if (w_accept)      w_state_nxt = ST_RD_TS;
        else if (w_expire) w_state_nxt = ST_GAP;
      end
      ST_RD_TS: begin
        if (w_accept)      w_state_nxt = ST_CHECK;
        else if (w_expire) w_state_nxt = ST_GAP;
      end
      ST_CHECK: w_state_nxt = ST_DONE;
      ST_GAP: begin
        if (w_can_retry) w_state_nxt = ST_RD_ID;
        else             w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    w_read_nxt = (w_state_nxt == ST_RD_ID) || (w_state_nxt == ST_RD_TS);
    w_addr_nxt = (w_state_nxt == ST_RD_TS);
    w_busy_nxt = w_read_nxt || (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_GAP);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // State register; the auto-start request lives only for the first
  // cycle after reset release.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_auto_pend <= AUTO_START;
    end else begin
      r_state     <= w_state_nxt;
      r_auto_pend <= 1'b0;
    end
  end

  // Registered bus strobes and sequence status.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_read <= 1'b0;
      r_addr <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_read <= w_read_nxt;
      r_addr <= w_addr_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Stall counter: counts consecutive waitrequest cycles of one access and
  // restarts on accept or any state change.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_cnt <= 16'd0;
    end else if (w_in_read && avm.avm_waitrequest && (w_state_nxt == r_state)) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end else begin
      r_wait_cnt <= 16'd0;
    end
  end

  // Retry counter: cleared when a sequence is launched, bumped per retry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retry_cnt <= 4'd0;
    end else if (w_launch) begin
      r_retry_cnt <= 4'd0;
    end else if ((r_state == ST_GAP) && w_can_retry) begin
      r_retry_cnt <= r_retry_cnt + 4'd1;
    end
  end

  // Sticky result flags: cleared on launch, set by the compare or forced
  // to failure when retries are exhausted.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_sysid_ok    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (w_launch) begin
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_sysid_ok    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_id_ok       <= (r_id_value == EXPECTED_ID);
      r_ts_ok       <= (r_ts_value == EXPECTED_TS);
      r_sysid_ok    <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TS);
    end else if ((r_state == ST_GAP) && !w_can_retry) begin
      r_id_ok       <= 1'b0;
      r_ts_ok       <= 1'b0;
      r_sysid_ok    <= 1'b0;
      r_timeout_err <= 1'b1;
    end
  end

  // Captured words: updated only on an accepted read, never cleared by start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
    end else if (w_accept) begin
      if (r_state == ST_RD_ID) r_id_value <= avm.avm_readdata;
      else                     r_ts_value <= avm.avm_readdata;
    end
  end

  assign avm.avm_read    = r_read;
  assign avm.avm_address = r_addr;
  assign busy            = r_busy;
  assign done            = r_done;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign sysid_ok        = r_sysid_ok;
  assign timeout_err     = r_timeout_err;
  assign id_value        = r_id_value;
  assign ts_value        = r_ts_value;

endmodule
`default_nettype wire

// File: tb/tb_sysid_check_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_sysid_check_ctrl
// Description : Scoreboard bench for sysid_check_ctrl with a stalling sysid
//               slave model and a cycle-cost reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_check_ctrl;

  localparam logic [31:0] C_EXP_ID = 32'h88888888;
  localparam logic [31:0] C_EXP_TS = 32'h5844ABF9;
  localparam int unsigned C_TMO    = 16;
  localparam int unsigned C_RETRY  = 2;

  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic start  = 1'b0;
  logic start2 = 1'b0;

  always #5 clock = ~clock;

  logic        busy, done, id_ok, ts_ok, sysid_ok, timeout_err;
  logic [31:0] id_value, ts_value;
  logic        busy2, done2, id_ok2, ts_ok2, sysid_ok2, timeout_err2;
  logic [31:0] id_value2, ts_value2;

  sysid_check_ctrl_if bus ();
  sysid_check_ctrl_if bus2 ();

  sysid_check_ctrl #(
    .EXPECTED_ID(C_EXP_ID), .EXPECTED_TS(C_EXP_TS),
    .TIMEOUT_CYCLES(C_TMO), .MAX_RETRY(C_RETRY), .AUTO_START(1'b1)
  ) u_dut (
    .clock(clock), .reset(reset), .start(start), .avm(bus),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok),
    .sysid_ok(sysid_ok), .timeout_err(timeout_err),
    .id_value(id_value), .ts_value(ts_value)
  );

  sysid_check_ctrl #(
    .EXPECTED_ID(C_EXP_ID), .EXPECTED_TS(C_EXP_TS),
    .TIMEOUT_CYCLES(C_TMO), .MAX_RETRY(C_RETRY), .AUTO_START(1'b0)
  ) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .avm(bus2),
    .busy(busy2), .done(done2), .id_ok(id_ok2), .ts_ok(ts_ok2),
    .sysid_ok(sysid_ok2), .timeout_err(timeout_err2),
    .id_value(id_value2), .ts_value(ts_value2)
  );

  // Second instance sees an ideal zero-wait sysid slave.
  assign bus2.avm_waitrequest = 1'b0;
  assign bus2.avm_readdata    = bus2.avm_address ? C_EXP_TS : C_EXP_ID;

  typedef struct {
    int unsigned cyc;
    bit          idok;
    bit          tsok;
    bit          tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned slave_q[$];
  int unsigned cyc      = 0;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] id_data  = C_EXP_ID;
  logic [31:0] ts_data  = C_EXP_TS;
  logic [31:0] m_idv    = 32'd0;
  logic [31:0] m_tsv    = 32'd0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mode 0: random stall lengths incl. the timeout boundary; 1: stuck; 2: fixed
  function automatic int unsigned gen_wait(input int mode, input int unsigned fixed);
    int unsigned r;
    if (mode == 1) return 1000;
    if (mode == 2) return fixed;
    r = $urandom_range(0, 11);
    if (r < 7)  return $urandom_range(0, 3);
    if (r == 7) return C_TMO - 1;
    if (r == 8) return C_TMO;
    return 0;
  endfunction

  // Reference: each access costs (stall+1) cycles if it completes, or
  // TIMEOUT+1 cycles if it stalls TIMEOUT times; a completed sequence adds
  // one compare cycle; done lands after the last cost.
  function automatic void model_run(input int unsigned s, input int mode, input int unsigned fixed);
    exp_t        e;
    int unsigned cost = 0;
    int unsigned w;
    bit          ok;
    bit          tmo  = 1'b0;
    for (int a = 0; a <= int'(C_RETRY); a++) begin
      ok = 1'b1;
      for (int acc = 0; acc < 2; acc++) begin
        w = gen_wait(mode, fixed);
        slave_q.push_back(w);
        if (w >= C_TMO) begin
          cost += C_TMO + 1;
          ok = 1'b0;
          break;
        end
        cost += w + 1;
        if (acc == 0) m_idv = id_data;
        else          m_tsv = ts_data;
      end
      if (ok) break;
      if (a == int'(C_RETRY)) tmo = 1'b1;
    end
    e.cyc  = s + 1 + cost + (tmo ? 0 : 1);
    e.tmo  = tmo;
    e.idok = !tmo && (m_idv == C_EXP_ID);
    e.tsok = !tmo && (m_tsv == C_EXP_TS);
    e.idv  = m_idv;
    e.tsv  = m_tsv;
    sb_q.push_back(e);
  endfunction

  // Sysid slave with per-access stall lengths taken from slave_q.
  int unsigned rem      = 0;
  bit          active   = 1'b0;
  bit          cur_read = 1'b0;
  initial begin
    bus.avm_waitrequest = 1'b0;
    bus.avm_readdata    = 32'd0;
  end
  always @(posedge clock) begin
    if (reset) active = 1'b0;
    else if (cur_read && active) begin
      if (rem > 0) rem--;
      else         active = 1'b0;
    end
    #2;
    cur_read = bus.avm_read;
    if (!cur_read) active = 1'b0;
    else if (!active) begin
      active = 1'b1;
      rem    = (slave_q.size() > 0) ? slave_q.pop_front() : 0;
    end
    bus.avm_waitrequest = active && (rem > 0);
    bus.avm_readdata    = bus.avm_address ? ts_data : id_data;
  end

  // Monitor: address stability under stall and done-pulse scoreboard.
  bit   prev_stall = 1'b0;
  logic prev_addr  = 1'b0;
  exp_t mon_e;
  always @(negedge clock) begin
    if (prev_stall && bus.avm_read) chk("addr_stable", 32'(bus.avm_address), 32'(prev_addr));
    prev_stall = bus.avm_read && bus.avm_waitrequest && !reset;
    prev_addr  = bus.avm_address;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("id_ok", 32'(id_ok), 32'(mon_e.idok));
        chk("ts_ok", 32'(ts_ok), 32'(mon_e.tsok));
        chk("sysid_ok", 32'(sysid_ok), 32'(mon_e.idok & mon_e.tsok));
        chk("timeout_err", 32'(timeout_err), 32'(mon_e.tmo));
        chk("id_value", id_value, mon_e.idv);
        chk("ts_value", ts_value, mon_e.tsv);
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL run_timeout: %0d results pending after %0d cycles, expected 0", sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  // One-cycle start pulse from IDLE; cycle 1 must show cleared flags and
  // the ID read.
  task automatic launch(input int mode, input int unsigned fixed);
    start = 1'b1;
    model_run(cyc, mode, fixed);
    tick();
    start = 1'b0;
    chk("c1_id_ok", 32'(id_ok), 32'd0);
    chk("c1_ts_ok", 32'(ts_ok), 32'd0);
    chk("c1_sysid_ok", 32'(sysid_ok), 32'd0);
    chk("c1_timeout_err", 32'(timeout_err), 32'd0);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_read", 32'(bus.avm_read), 32'd1);
    chk("c1_addr", 32'(bus.avm_address), 32'd0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_read"}, 32'(bus.avm_read), 32'd0);
    chk({tag, "_addr"}, 32'(bus.avm_address), 32'd0);
    chk({tag, "_id_ok"}, 32'(id_ok), 32'd0);
    chk({tag, "_ts_ok"}, 32'(ts_ok), 32'd0);
    chk({tag, "_sysid_ok"}, 32'(sysid_ok), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_id_value"}, id_value, 32'd0);
    chk({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned s2;

    // Reset values, then the automatic run after release.
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_values("rst");
    chk("rst_busy2", 32'(busy2), 32'd0);
    reset = 1'b0;
    model_run(cyc, 2, 0);
    wait_done(100);

    // Timestamp one off: only the timestamp compare fails.
    ts_data = C_EXP_TS ^ 32'h1;
    launch(2, 0);
    wait_done(100);
    ts_data = C_EXP_TS;

    // Three wait states on each access.
    launch(2, 3);
    wait_done(100);

    // Waitrequest stuck high: three attempts then abort.
    launch(1, 0);
    wait_done(200);

    // Start pulse during the timestamp read must be dropped.
    launch(2, 3);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(100);
    launch(2, 0);
    wait_done(100);

    // Randomised data corruption and stall lengths.
    for (int i = 0; i < 24; i++) begin
      id_data = ($urandom_range(0, 3) == 0) ? (C_EXP_ID ^ (32'h1 << $urandom_range(0, 31))) : C_EXP_ID;
      ts_data = ($urandom_range(0, 3) == 0) ? (C_EXP_TS ^ (32'h1 << $urandom_range(0, 31))) : C_EXP_TS;
      repeat ($urandom_range(0, 3)) tick();
      launch(0, 0);
      wait_done(400);
    end
    id_data = C_EXP_ID;
    ts_data = C_EXP_TS;

    // Start held high across DONE re-launches right after it.
    start = 1'b1;
    model_run(cyc, 0, 0);
    s2 = sb_q[0].cyc + 1;
    model_run(s2, 0, 0);
    while (cyc < s2 + 1) tick();
    start = 1'b0;
    wait_done(400);

    // Reset during the stalled ID read.
    launch(2, 5);
    tick();
    reset = 1'b1;
    sb_q.delete();
    slave_q.delete();
    m_idv = 32'd0;
    m_tsv = 32'd0;
    tick();
    chk_reset_values("midrst");
    tick();
    reset = 1'b0;
    model_run(cyc, 2, 0);
    wait_done(100);

    // Instance without auto start stays idle until asked.
    for (int i = 0; i < 6; i++) begin
      chk("dut2_idle_busy", 32'(busy2), 32'd0);
      chk("dut2_idle_read", 32'(bus2.avm_read), 32'd0);
      tick();
    end
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("dut2_c1_busy", 32'(busy2), 32'd1);
    repeat (2) tick();
    chk("dut2_c3_done", 32'(done2), 32'd0);
    tick();
    chk("dut2_done", 32'(done2), 32'd1);
    chk("dut2_id_ok", 32'(id_ok2), 32'd1);
    chk("dut2_ts_ok", 32'(ts_ok2), 32'd1);
    chk("dut2_sysid_ok", 32'(sysid_ok2), 32'd1);
    chk("dut2_timeout_err", 32'(timeout_err2), 32'd0);
    chk("dut2_id_value", id_value2, C_EXP_ID);
    chk("dut2_ts_value", ts_value2, C_EXP_TS);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
